// File: rtl/biriscv_mul_pipe_pkg.sv
// biriscv_mul_pipe_pkg: shared RV32M/RV64M multiply decode constants and op-class encoding
package biriscv_mul_pipe_pkg;

    localparam logic [31:0] INST_MUL         = 32'h02000033;
    localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
    localparam logic [31:0] INST_MULH        = 32'h02001033;
    localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
    localparam logic [31:0] INST_MULHSU      = 32'h02002033;
    localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_MULHU       = 32'h02003033;
    localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

    // Op class equals funct3[1:0] of the instruction word
    typedef logic [1:0] mul_op_t;
    localparam mul_op_t MUL_OP_MUL    = 2'd0;
    localparam mul_op_t MUL_OP_MULH   = 2'd1;
    localparam mul_op_t MUL_OP_MULHSU = 2'd2;
    localparam mul_op_t MUL_OP_MULHU  = 2'd3;

    function automatic logic is_mul_inst(input logic [31:0] inst);
        return ((inst & INST_MUL_MASK) == INST_MUL) ||
               ((inst & INST_MULH_MASK) == INST_MULH) ||
               ((inst & INST_MULHSU_MASK) == INST_MULHSU) ||
               ((inst & INST_MULHU_MASK) == INST_MULHU);
    endfunction

endpackage

// File: rtl/biriscv_mul_delay_stage.sv
// biriscv_mul_delay_stage: valid/rd/data delay register with hold, flush and sync reset
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   hold_i, flush_i    : freeze stage / clear valid (flush wins)
//   valid_i/rd_i/data_i: upstream stage
//   valid_o/rd_o/data_o: registered stage
module biriscv_mul_delay_stage #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         hold_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [4:0]   rd_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [4:0]   rd_o,
    output logic [W-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            rd_o    <= '0;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (!hold_i) begin
            valid_o <= valid_i;
            rd_o    <= rd_i;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/biriscv_mul_pipe.sv
// biriscv_mul_pipe: parametrised pipelined RV32M/RV64M multiplier with flush and rd scoreboard mask
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   opcode_*_i                    : issue slot (valid, instruction, rd, rs1, rs2)
//   hold_i, flush_i               : stall all stages / kill all in-flight ops
//   writeback_valid/rd_idx/value_o: result from the last stage
//   pending_rd_mask_o             : rd bits of every valid in-flight op (rd!=0)
//   busy_o                        : any stage valid
module biriscv_mul_pipe
    import biriscv_mul_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STAGES     = 2,
    parameter bit CLEAR_IDLE = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic [31:0]     pending_rd_mask_o,
    output logic            busy_o
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("biriscv_mul_pipe: STAGES must be 2..4");
    end

    logic            accept;
    mul_op_t         op;
    logic [XLEN:0]   a_ext, b_ext;
    logic [XLEN:0]   op_a_e1, op_b_e1;
    logic            hi_e1, valid_e1, valid_e2;
    logic [4:0]      rd_e1, rd_e2;
    logic [XLEN-1:0] res_e2;
    logic [2*XLEN-1:0] prod;

    logic            stage_valid [STAGES];
    logic [4:0]      stage_rd    [STAGES];
    logic [XLEN-1:0] stage_data  [STAGES];

    always_comb begin
        op     = mul_op_t'(opcode_opcode_i[13:12]);
        accept = opcode_valid_i & is_mul_inst(opcode_opcode_i) & ~hold_i & ~flush_i;
        a_ext  = {(op == MUL_OP_MULH || op == MUL_OP_MULHSU) & opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
        b_ext  = {(op == MUL_OP_MULH) & opcode_rb_operand_i[XLEN-1], opcode_rb_operand_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_e1 <= 1'b0;
            op_a_e1  <= '0;
            op_b_e1  <= '0;
            hi_e1    <= 1'b0;
            rd_e1    <= '0;
        end else if (flush_i || !hold_i) begin
            valid_e1 <= accept;
            if (accept) begin
                op_a_e1 <= a_ext;
                op_b_e1 <= b_ext;
                hi_e1   <= (op != MUL_OP_MUL);
                rd_e1   <= opcode_rd_idx_i;
            end else if (CLEAR_IDLE) begin
                op_a_e1 <= '0;
                op_b_e1 <= '0;
            end
        end
    end

    // Product modulo 2^(2*XLEN) is all that is ever selected, so sign
    // extension to 2*XLEN bits gives the same low/high words as a wider one.
    always_comb begin
        prod = {{(XLEN-1){op_a_e1[XLEN]}}, op_a_e1} * {{(XLEN-1){op_b_e1[XLEN]}}, op_b_e1};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_e2 <= 1'b0;
            rd_e2    <= '0;
            res_e2   <= '0;
        end else if (flush_i) begin
            valid_e2 <= 1'b0;
        end else if (!hold_i) begin
            valid_e2 <= valid_e1;
            rd_e2    <= rd_e1;
            res_e2   <= stage_data[0];
        end
    end

    assign stage_valid[0] = valid_e1;
    assign stage_rd[0]    = rd_e1;
    assign stage_data[0]  = hi_e1 ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign stage_valid[1] = valid_e2;
    assign stage_rd[1]    = rd_e2;
    assign stage_data[1]  = res_e2;

    for (genvar s = 2; s < STAGES; s++) begin : g_delay
        biriscv_mul_delay_stage #(.W(XLEN)) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .hold_i  (hold_i),
            .flush_i (flush_i),
            .valid_i (stage_valid[s-1]),
            .rd_i    (stage_rd[s-1]),
            .data_i  (stage_data[s-1]),
            .valid_o (stage_valid[s]),
            .rd_o    (stage_rd[s]),
            .data_o  (stage_data[s])
        );
    end

    assign writeback_valid_o  = stage_valid[STAGES-1];
    assign writeback_rd_idx_o = stage_rd[STAGES-1];
    assign writeback_value_o  = stage_data[STAGES-1];

    always_comb begin
        pending_rd_mask_o = '0;
        busy_o            = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy_o = busy_o | stage_valid[s];
            if (stage_valid[s] && stage_rd[s] != 5'd0)
                pending_rd_mask_o[stage_rd[s]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_biriscv_mul_pipe.sv
// tb_biriscv_mul_pipe: directed checks of the multiplier at 32b/2-stage, 32b/4-stage and 64b/2-stage
module tb_biriscv_mul_pipe;

    localparam logic [31:0] OP_MUL    = 32'h02000033;
    localparam logic [31:0] OP_MULH   = 32'h02001033;
    localparam logic [31:0] OP_MULHSU = 32'h02002033;
    localparam logic [31:0] OP_MULHU  = 32'h02003033;
    localparam logic [31:0] OP_ADD    = 32'h00c58533;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] opc;
    logic [4:0]  rd;
    logic [63:0] a, b;
    logic        hold, flush;

    logic        wv2, by2, wv4, by4, wv64, by64;
    logic [4:0]  wr2, wr4, wr64;
    logic [31:0] wd2, wd4, pm2, pm4, pm64;
    logic [63:0] wd64;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    biriscv_mul_pipe #(.XLEN(32), .STAGES(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(valid), .opcode_opcode_i(opc),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(a[31:0]), .opcode_rb_operand_i(b[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wv2), .writeback_rd_idx_o(wr2),
        .writeback_value_o(wd2), .pending_rd_mask_o(pm2), .busy_o(by2)
    );

    biriscv_mul_pipe #(.XLEN(32), .STAGES(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(valid), .opcode_opcode_i(opc),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(a[31:0]), .opcode_rb_operand_i(b[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wv4), .writeback_rd_idx_o(wr4),
        .writeback_value_o(wd4), .pending_rd_mask_o(pm4), .busy_o(by4)
    );

    biriscv_mul_pipe #(.XLEN(64), .STAGES(2)) u_d64 (
        .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(valid), .opcode_opcode_i(opc),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(a), .opcode_rb_operand_i(b),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wv64), .writeback_rd_idx_o(wr64),
        .writeback_value_o(wd64), .pending_rd_mask_o(pm64), .busy_o(by64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] o, input logic [4:0] r, input logic [63:0] x, input logic [63:0] y);
        valid = 1'b1;
        opc   = o;
        rd    = r;
        a     = x;
        b     = y;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; opc = '0; rd = '0; a = '0; b = '0; hold = 1'b0; flush = 1'b0;
        step();
        step();
        check("rst_wv", wv2, 0);
        check("rst_wr", wr2, 0);
        check("rst_wd", wd2, 0);
        check("rst_pm", pm2, 0);
        check("rst_busy", by2, 0);
        check("rst_wv4", wv4, 0);
        rst_n = 1'b1;

        // MUL 7 x -3, 2-stage latency
        present(OP_MUL, 5'd5, 64'd7, 64'hFFFF_FFFD);
        step();
        valid = 1'b0;
        check("mul_e1_wv", wv2, 0);
        check("mul_e1_pm", pm2, 32'h20);
        check("mul_e1_busy", by2, 1);
        step();
        check("mul_wv", wv2, 1);
        check("mul_wd", wd2, 32'hFFFF_FFEB);
        check("mul_wr", wr2, 5);
        check("mul_wb_pm", pm2, 32'h20);
        step();
        check("mul_done_wv", wv2, 0);
        check("mul_done_pm", pm2, 0);
        check("mul_done_busy", by2, 0);

        // back-to-back ops in issue order
        present(OP_MULH, 5'd1, 64'h8000_0000, 64'h8000_0000);
        step();
        present(OP_MULHSU, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        step();
        check("b2b_mulh_wv", wv2, 1);
        check("b2b_mulh_wd", wd2, 32'h4000_0000);
        check("b2b_mulh_wr", wr2, 1);
        present(OP_MULHU, 5'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        step();
        check("b2b_mulhsu_wv", wv2, 1);
        check("b2b_mulhsu_wd", wd2, 32'hFFFF_FFFF);
        check("b2b_mulhsu_wr", wr2, 2);
        present(OP_MUL, 5'd4, 64'h1_0000, 64'h1_0000);
        step();
        check("b2b_mulhu_wv", wv2, 1);
        check("b2b_mulhu_wd", wd2, 32'hFFFF_FFFE);
        check("b2b_mulhu_wr", wr2, 3);
        valid = 1'b0;
        step();
        check("b2b_mul_wv", wv2, 1);
        check("b2b_mul_wd", wd2, 32'h0);
        check("b2b_mul_wr", wr2, 4);
        step();
        check("b2b_end_wv", wv2, 0);
        step();
        step();

        // 4-stage with 3 held cycles mid-flight
        present(OP_MUL, 5'd6, 64'd3, 64'd4);
        step();
        valid = 1'b0;
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_mid_wv", wv4, 0);
            check("hold_mid_busy", by4, 1);
        end
        hold = 1'b0;
        step();
        check("hold_e6_wv", wv4, 0);
        step();
        check("hold_wv", wv4, 1);
        check("hold_wd", wd4, 12);
        check("hold_wr", wr4, 6);
        hold = 1'b1;
        step();
        check("hold_out_wv", wv4, 1);
        check("hold_out_wd", wd4, 12);
        hold = 1'b0;
        step();
        check("hold_nodup_wv", wv4, 0);
        check("hold_end_busy", by4, 0);

        // flush (with hold) kills two in-flight ops
        present(OP_MUL, 5'd3, 64'd1, 64'd1);
        step();
        rd = 5'd4;
        step();
        check("flush_pre_pm", pm4, 32'h18);
        valid = 1'b0;
        flush = 1'b1;
        hold  = 1'b1;
        step();
        check("flush_wv", wv4, 0);
        check("flush_pm", pm4, 0);
        check("flush_busy", by4, 0);
        check("flush_busy2", by2, 0);
        flush = 1'b0;
        hold  = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | wv4;
        end
        check("flush_no_wb", seen, 0);

        // reset with every stage occupied
        present(OP_MUL, 5'd1, 64'd2, 64'd3);
        step();
        rd = 5'd2;
        step();
        rd = 5'd3;
        step();
        rd = 5'd7;
        step();
        check("full_busy", by4, 1);
        check("full_pm", pm4, 32'h8E);
        valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst_wv", wv4, 0);
        check("midrst_wr", wr4, 0);
        check("midrst_wd", wd4, 0);
        check("midrst_pm", pm4, 0);
        check("midrst_busy", by4, 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | wv4 | wv2;
        end
        check("midrst_no_wb", seen, 0);

        // non-mul opcode never accepted
        present(OP_ADD, 5'd9, 64'd3, 64'd3);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | wv2 | wv4 | by2 | by4 | (|pm2) | (|pm4);
        end
        valid = 1'b0;
        check("add_ignored", seen, 0);

        // 64-bit MULHU and MUL to x0
        present(OP_MULHU, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        present(OP_MUL, 5'd0, 64'd5, 64'd6);
        step();
        valid = 1'b0;
        check("x64_mulhu_wv", wv64, 1);
        check("x64_mulhu_wd", wd64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64_mulhu_wr", wr64, 8);
        check("x64_pm_rd0_e1", pm64, 32'h100);
        step();
        check("x64_mul_wv", wv64, 1);
        check("x64_mul_wd", wd64, 30);
        check("x64_mul_wr", wr64, 0);
        check("x64_pm_rd0_wb", pm64, 0);
        step();
        check("x64_end_wv", wv64, 0);
        check("x64_end_busy", by64, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
